// File: rtl/data_sync_ctrl.sv
// data_sync_ctrl
// Destination-side controller for a multi-bit clock-domain crossing.
// The source raises a request (already passed through a 2-flop bit
// synchronizer), holds its data bus steady, and waits for ACK. This block
// captures the bus into a stable register once the consumer is ready,
// strobes ENABLE_PULSE for one cycle and raises ACK until the request
// drops. A request that never drops is abandoned after TIMEOUT_CYCLES
// cycles of ACK, and the block then waits for the request to go low
// before it will accept another word.

module data_sync_ctrl #(
  parameter int unsigned BUS_WIDTH      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 REQ_SYNC,
  input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
  input  logic                 DST_READY,
  output logic [BUS_WIDTH-1:0] SYNC_BUS,
  output logic                 ENABLE_PULSE,
  output logic                 ACK,
  output logic                 BUSY,
  output logic                 TIMEOUT_ERR
);

  // Counter is just wide enough to hold TIMEOUT_CYCLES; a disabled
  // timeout still gets a 1-bit counter so the declarations stay legal.
  localparam int unsigned CNT_W =
    (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  // The counter reads k-1 during the k-th cycle of ACK_HI, so the
  // last permitted cycle is the one where it equals TIMEOUT_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_WAIT_LOW = 2'd0,
    ST_IDLE     = 2'd1,
    ST_WAIT_DST = 2'd2,
    ST_ACK_HI   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [BUS_WIDTH-1:0] sync_bus_q, sync_bus_d;
  logic                 enable_pulse_q, enable_pulse_d;
  logic                 ack_q, ack_d;
  logic                 timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  // Next-state and next-output decode for the handshake sequencer.
  always_comb begin
    state_d        = state_q;
    sync_bus_d     = sync_bus_q;
    enable_pulse_d = 1'b0;
    ack_d          = ack_q;
    timeout_err_d  = 1'b0;
    cnt_d          = cnt_q;

    case (state_q)
      ST_WAIT_LOW: begin
        // A request that was already high (across reset or after a
        // timeout) must be seen low before it can start a transfer.
        ack_d = 1'b0;
        if (!REQ_SYNC) begin
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (REQ_SYNC) begin
          if (DST_READY) begin
            sync_bus_d     = UNSYNC_BUS;
            enable_pulse_d = 1'b1;
            ack_d          = 1'b1;
            cnt_d          = '0;
            state_d        = ST_ACK_HI;
          end else begin
            state_d = ST_WAIT_DST;
          end
        end
      end

      ST_WAIT_DST: begin
        // A request withdrawn while waiting for the consumer is treated
        // as aborted, even if the consumer becomes ready on the same edge.
        ack_d = 1'b0;
        if (!REQ_SYNC) begin
          state_d = ST_IDLE;
        end else if (DST_READY) begin
          sync_bus_d     = UNSYNC_BUS;
          enable_pulse_d = 1'b1;
          ack_d          = 1'b1;
          cnt_d          = '0;
          state_d        = ST_ACK_HI;
        end
      end

      ST_ACK_HI: begin
        // Normal completion wins over a timeout expiring on the same edge.
        cnt_d = cnt_q + CNT_W'(1);
        if (!REQ_SYNC) begin
          ack_d   = 1'b0;
          state_d = ST_IDLE;
        end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
          ack_d         = 1'b0;
          timeout_err_d = 1'b1;
          state_d       = ST_WAIT_LOW;
        end
      end

      default: begin
        ack_d   = 1'b0;
        state_d = ST_WAIT_LOW;
      end
    endcase
  end

  // State and output registers; reset returns everything to a safe,
  // busy, non-acknowledging state with a cleared data register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= ST_WAIT_LOW;
      sync_bus_q     <= '0;
      enable_pulse_q <= 1'b0;
      ack_q          <= 1'b0;
      timeout_err_q  <= 1'b0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      sync_bus_q     <= sync_bus_d;
      enable_pulse_q <= enable_pulse_d;
      ack_q          <= ack_d;
      timeout_err_q  <= timeout_err_d;
      cnt_q          <= cnt_d;
    end
  end

  assign SYNC_BUS     = sync_bus_q;
  assign ENABLE_PULSE = enable_pulse_q;
  assign ACK          = ack_q;
  assign TIMEOUT_ERR  = timeout_err_q;
  assign BUSY         = (state_q != ST_IDLE);

`ifndef SYNTHESIS
  // The two strobes describe mutually exclusive events.
  a_strobes_exclusive : assert property (
    @(posedge CLK) !(enable_pulse_q && timeout_err_q))
    else $error("data_sync_ctrl: ENABLE_PULSE and TIMEOUT_ERR both high");

  // ENABLE_PULSE lasts a single cycle.
  a_pulse_single : assert property (
    @(posedge CLK) disable iff (RST) enable_pulse_q |=> !enable_pulse_q)
    else $error("data_sync_ctrl: ENABLE_PULSE longer than one cycle");

  // TIMEOUT_ERR lasts a single cycle.
  a_err_single : assert property (
    @(posedge CLK) disable iff (RST) timeout_err_q |=> !timeout_err_q)
    else $error("data_sync_ctrl: TIMEOUT_ERR longer than one cycle");

  // ACK is high exactly while the sequencer sits in ACK_HI.
  a_ack_state : assert property (
    @(posedge CLK) ack_q == (state_q == ST_ACK_HI))
    else $error("data_sync_ctrl: ACK inconsistent with state");
`endif

endmodule

// File: tb/tb_data_sync_ctrl.sv
// Testbench for data_sync_ctrl: directed handshake scenarios with a
// scoreboard of captured words checked by an independent monitor.

module tb_data_sync_ctrl;

  localparam int unsigned BW   = 8;
  localparam int unsigned TOUT = 16;

  logic          CLK;
  logic          RST;
  logic          REQ_SYNC;
  logic [BW-1:0] UNSYNC_BUS;
  logic          DST_READY;
  logic [BW-1:0] SYNC_BUS;
  logic          ENABLE_PULSE;
  logic          ACK;
  logic          BUSY;
  logic          TIMEOUT_ERR;

  int total;
  int bad;
  int pulseCount;
  int pushCount;
  logic [BW-1:0] expQ[$];

  data_sync_ctrl #(
    .BUS_WIDTH      (BW),
    .TIMEOUT_CYCLES (TOUT)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .REQ_SYNC     (REQ_SYNC),
    .UNSYNC_BUS   (UNSYNC_BUS),
    .DST_READY    (DST_READY),
    .SYNC_BUS     (SYNC_BUS),
    .ENABLE_PULSE (ENABLE_PULSE),
    .ACK          (ACK),
    .BUSY         (BUSY),
    .TIMEOUT_ERR  (TIMEOUT_ERR)
  );

  // Free-running 10 ns clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drive the source/consumer inputs; the next tick samples them.
  task automatic applyStimulus(input logic req, input logic rdy, input logic [BW-1:0] bus);
    REQ_SYNC   = req;
    DST_READY  = rdy;
    UNSYNC_BUS = bus;
  endtask

  // Record a word the DUT is expected to capture.
  task automatic expectCapture(input logic [BW-1:0] word);
    expQ.push_back(word);
    pushCount++;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: every ENABLE_PULSE must match the oldest expected word,
  // and the two strobes must never coincide.
  always @(negedge CLK) begin
    if (ENABLE_PULSE === 1'b1) begin
      pulseCount++;
      total++;
      if (expQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_pulse actual=0x%0h expected=no_pulse at %0t", SYNC_BUS, $time);
      end else begin
        logic [BW-1:0] exp;
        exp = expQ.pop_front();
        if (SYNC_BUS !== exp) begin
          bad++;
          $display("[TB] FAIL capture_data actual=0x%0h expected=0x%0h at %0t", SYNC_BUS, exp, $time);
        end
      end
      if (TIMEOUT_ERR === 1'b1) begin
        total++;
        bad++;
        $display("[TB] FAIL strobe_overlap actual=1 expected=0 at %0t", $time);
      end
    end
  end

  // Global bound so a stuck design still reaches the summary line.
  initial begin
    #200000;
    bad++;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int ackCycles;
    bit errSeen;

    total      = 0;
    bad        = 0;
    pulseCount = 0;
    pushCount  = 0;

    // Reset held with the request already high.
    RST = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'h00);
    tick();
    tick();
    checkOutput("rst_ack", 32'(ACK), 32'd0);
    checkOutput("rst_sync_bus", 32'(SYNC_BUS), 32'h00);
    checkOutput("rst_busy", 32'(BUSY), 32'd1);
    checkOutput("rst_err", 32'(TIMEOUT_ERR), 32'd0);
    RST = 1'b0;
    tick();
    checkOutput("held_req_busy", 32'(BUSY), 32'd1);
    checkOutput("held_req_ack", 32'(ACK), 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00);
    tick();
    checkOutput("idle_busy", 32'(BUSY), 32'd0);

    // Basic transfer.
    applyStimulus(1'b1, 1'b1, 8'hA5);
    expectCapture(8'hA5);
    tick();
    checkOutput("basic_sync_bus", 32'(SYNC_BUS), 32'hA5);
    checkOutput("basic_pulse", 32'(ENABLE_PULSE), 32'd1);
    checkOutput("basic_ack", 32'(ACK), 32'd1);
    tick();
    checkOutput("basic_pulse_fall", 32'(ENABLE_PULSE), 32'd0);
    checkOutput("basic_ack_held", 32'(ACK), 32'd1);
    applyStimulus(1'b0, 1'b1, 8'hA5);
    tick();
    checkOutput("basic_ack_release", 32'(ACK), 32'd0);
    checkOutput("basic_idle", 32'(BUSY), 32'd0);

    // Backpressure: consumer not ready for 5 cycles.
    applyStimulus(1'b1, 1'b0, 8'h3C);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("bp_ack", 32'(ACK), 32'd0);
      checkOutput("bp_busy", 32'(BUSY), 32'd1);
      checkOutput("bp_sync_hold", 32'(SYNC_BUS), 32'hA5);
    end
    applyStimulus(1'b1, 1'b1, 8'h3C);
    expectCapture(8'h3C);
    tick();
    checkOutput("bp_sync_bus", 32'(SYNC_BUS), 32'h3C);
    checkOutput("bp_pulse", 32'(ENABLE_PULSE), 32'd1);
    applyStimulus(1'b0, 1'b0, 8'h3C);
    tick();
    checkOutput("bp_ack_release", 32'(ACK), 32'd0);

    // Aborted request while waiting for the consumer.
    applyStimulus(1'b1, 1'b0, 8'h77);
    tick();
    checkOutput("abort_wait_busy", 32'(BUSY), 32'd1);
    applyStimulus(1'b0, 1'b1, 8'h77);
    tick();
    checkOutput("abort_idle", 32'(BUSY), 32'd0);
    checkOutput("abort_sync_hold", 32'(SYNC_BUS), 32'h3C);
    checkOutput("abort_ack", 32'(ACK), 32'd0);

    // Timeout: request stuck high.
    applyStimulus(1'b1, 1'b1, 8'h5A);
    expectCapture(8'h5A);
    tick();
    ackCycles = (ACK === 1'b1) ? 1 : 0;
    errSeen   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ACK === 1'b1) begin
        ackCycles++;
      end else begin
        errSeen = 1'b1;
        checkOutput("tout_err_pulse", 32'(TIMEOUT_ERR), 32'd1);
        break;
      end
    end
    checkOutput("tout_ack_fell", 32'(errSeen), 32'd1);
    checkOutput("tout_ack_cycles", 32'(ackCycles), 32'(TOUT));
    checkOutput("tout_sync_hold", 32'(SYNC_BUS), 32'h5A);
    checkOutput("tout_busy", 32'(BUSY), 32'd1);
    applyStimulus(1'b1, 1'b1, 8'h66);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("tout_no_recapture_ack", 32'(ACK), 32'd0);
      checkOutput("tout_err_single", 32'(TIMEOUT_ERR), 32'd0);
    end
    checkOutput("tout_no_recapture_bus", 32'(SYNC_BUS), 32'h5A);
    applyStimulus(1'b0, 1'b0, 8'h66);
    tick();
    checkOutput("tout_recover_idle", 32'(BUSY), 32'd0);

    // Timeout race: request falls in the last permitted ACK cycle.
    applyStimulus(1'b1, 1'b1, 8'hC3);
    expectCapture(8'hC3);
    tick();
    for (int i = 0; i < int'(TOUT) - 1; i++) begin
      tick();
    end
    checkOutput("race_ack_still_high", 32'(ACK), 32'd1);
    applyStimulus(1'b0, 1'b0, 8'hC3);
    tick();
    checkOutput("race_ack_release", 32'(ACK), 32'd0);
    checkOutput("race_no_err", 32'(TIMEOUT_ERR), 32'd0);
    checkOutput("race_idle", 32'(BUSY), 32'd0);
    tick();
    checkOutput("race_no_err_late", 32'(TIMEOUT_ERR), 32'd0);

    // Reset in the middle of a handshake.
    applyStimulus(1'b1, 1'b1, 8'hE7);
    expectCapture(8'hE7);
    tick();
    checkOutput("midrst_ack_before", 32'(ACK), 32'd1);
    RST = 1'b1;
    tick();
    checkOutput("midrst_ack", 32'(ACK), 32'd0);
    checkOutput("midrst_sync_bus", 32'(SYNC_BUS), 32'h00);
    checkOutput("midrst_busy", 32'(BUSY), 32'd1);
    RST = 1'b0;
    applyStimulus(1'b0, 1'b1, 8'hE7);
    tick();
    checkOutput("midrst_idle", 32'(BUSY), 32'd0);

    // Back-to-back words at minimum spacing.
    applyStimulus(1'b1, 1'b1, 8'h11);
    expectCapture(8'h11);
    tick();
    checkOutput("b2b_first", 32'(SYNC_BUS), 32'h11);
    applyStimulus(1'b0, 1'b1, 8'h11);
    tick();
    applyStimulus(1'b1, 1'b1, 8'h22);
    expectCapture(8'h22);
    tick();
    checkOutput("b2b_second", 32'(SYNC_BUS), 32'h22);
    checkOutput("b2b_second_ack", 32'(ACK), 32'd1);
    applyStimulus(1'b0, 1'b1, 8'h22);
    tick();
    tick();

    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
    checkOutput("pulse_count", 32'(pulseCount), 32'(pushCount));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_sync_ctrl.md
# data_sync_ctrl

Destination-domain controller for multi-bit clock-domain crossings. It sequences a 4-phase REQ/ACK handshake whose request arrives already synchronized by a 2-stage bit synchronizer. It captures the quasi-static source bus into a stable register, emits a one-cycle enable pulse to the consumer, and returns ACK for re-synchronization into the source domain. It applies destination backpressure and recovers from a stuck request with a timeout.

## Interface
- BUS_WIDTH, 8, width of the crossed data bus.
- TIMEOUT_CYCLES, 255, maximum number of cycles ACK stays high waiting for REQ to drop; 0 disables the timeout. The counter width is the minimum that holds TIMEOUT_CYCLES.

- CLK  in  1  destination clock; all logic is on the rising edge.
- RST  in  1  synchronous, active-high reset.
- REQ_SYNC  in  1  source request, already synchronized to CLK.
- UNSYNC_BUS  in  BUS_WIDTH  source data; stable while the request is high.
- DST_READY  in  1  consumer can accept a new word.
- SYNC_BUS  out  BUS_WIDTH  captured data, registered.
- ENABLE_PULSE  out  1  one-cycle strobe: SYNC_BUS has been updated.
- ACK  out  1  handshake acknowledge to the source domain, registered.
- BUSY  out  1  high in any state other than IDLE.
- TIMEOUT_ERR  out  1  one-cycle strobe: ACK was withdrawn because REQ did not drop.

## Operation
- States: WAIT_LOW, IDLE, WAIT_DST, ACK_HI. The reset state is WAIT_LOW.
- Reset values: SYNC_BUS=0, ENABLE_PULSE=0, ACK=0, TIMEOUT_ERR=0, counter=0, BUSY=1.
- WAIT_LOW: ACK=0.
  - REQ_SYNC=0 → IDLE.
  - A request held high across reset is never captured.
- IDLE: BUSY=0.
  - REQ_SYNC=1 and DST_READY=1 → capture. At that edge: SYNC_BUS<=UNSYNC_BUS, ENABLE_PULSE<=1, ACK<=1, counter<=0, state ACK_HI.
  - REQ_SYNC=1 and DST_READY=0 → WAIT_DST.
- WAIT_DST: hold with ACK=0.
  - DST_READY=1 → capture as above, → ACK_HI.
  - REQ_SYNC dropping while in WAIT_DST is an aborted request → IDLE, no capture, no pulse.
- ACK_HI: ACK=1, counter increments each cycle.
  - REQ_SYNC=0 → ACK<=0, → IDLE. Normal completion.
  - TIMEOUT_CYCLES≠0 and REQ_SYNC=1 in the TIMEOUT_CYCLES-th cycle of ACK_HI → ACK<=0, TIMEOUT_ERR<=1, → WAIT_LOW.
  - DST_READY is ignored in ACK_HI.
- Simultaneous REQ_SYNC=0 and timeout expiry: normal completion; TIMEOUT_ERR stays 0.
- SYNC_BUS changes only at a capture edge and holds between captures and through a timeout.
- ENABLE_PULSE and TIMEOUT_ERR are high for exactly one cycle per event and are never high together.
- RST=1 in any state, mid-handshake included: all outputs return to their reset values at the next edge and state goes to WAIT_LOW. SYNC_BUS clears to 0.

## Timing
- Capture latency: REQ_SYNC sampled high in IDLE with DST_READY=1 at edge N; SYNC_BUS, ENABLE_PULSE and ACK are valid after edge N.
- ENABLE_PULSE falls after edge N+1.
- Backpressure latency: capture occurs at the first edge where DST_READY=1 in WAIT_DST.
- ACK release: REQ_SYNC sampled low at edge M in ACK_HI gives ACK=0 after edge M.
- Back-to-back minimum: IDLE is occupied at least one cycle after completion, so the earliest next capture is at edge M+1.
- Timeout: ACK is high for exactly TIMEOUT_CYCLES cycles; TIMEOUT_ERR is high for the cycle after ACK falls.
- All outputs are registered or decoded from registered state only. BUSY is a state decode.

## Test plan
- Reset then idle: RST=1 for 2 cycles with REQ_SYNC=1 → ACK=0, SYNC_BUS=0x00, BUSY=1. REQ_SYNC=0 → BUSY=0 the next cycle, and no ENABLE_PULSE at any point.
- Basic transfer: UNSYNC_BUS=0xA5, REQ_SYNC=1, DST_READY=1 → after the next edge SYNC_BUS=0xA5, ENABLE_PULSE=1 for 1 cycle, ACK=1. REQ_SYNC=0 → ACK=0 next cycle, state IDLE.
- Backpressure: DST_READY=0 for 5 cycles with REQ_SYNC=1, UNSYNC_BUS=0x3C → ACK=0, BUSY=1, SYNC_BUS unchanged. DST_READY=1 → SYNC_BUS=0x3C with one ENABLE_PULSE. Separately, REQ_SYNC dropping in WAIT_DST → IDLE with no pulse.
- Timeout (TIMEOUT_CYCLES=16): REQ_SYNC held high → ACK high exactly 16 cycles, TIMEOUT_ERR=1 for 1 cycle, SYNC_BUS retained. There is no recapture until REQ_SYNC goes low and then high again.
- Timeout race: REQ_SYNC falls in the 16th ACK_HI cycle → normal completion, TIMEOUT_ERR=0.
- Reset mid-handshake and back-to-back traffic:
  - RST asserted in ACK_HI → ACK=0, SYNC_BUS=0x00 next cycle.
  - Two sequential words 0x11 and 0x22 at minimum spacing → exactly two ENABLE_PULSEs with SYNC_BUS matching each word.
